// File: rtl/lpddr2_bridge_pkg.sv
// Shared types and defaults for the CPU-to-LPDDR2 Avalon bridge.
package lpddr2_bridge_pkg;

    localparam int unsigned DEF_ADDR_W  = 27;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_BE_W    = DEF_DATA_W / 8;
    localparam int unsigned DEF_TIMEOUT = 1024;

    localparam logic [DEF_BE_W-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lpddr2_rd_buffer.sv
// One-entry read buffer: holds the last fetched word so a stalled CPU that keeps
// read_req high is answered without another controller access.
module lpddr2_rd_buffer
    import lpddr2_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit_c,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              inv_en,
    output logic              buf_valid,
    output logic [DATA_W-1:0] buf_data
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Fill and invalidate win over a write-through update of the same entry
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (upd_en && valid_q && (tag_q == upd_addr)) begin
            data_d = upd_data;
        end
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_addr;
            data_d  = fill_data;
        end
        if (inv_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_c     = valid_q && (tag_q == lookup_addr);
    assign buf_valid = valid_q;
    assign buf_data  = data_q;

endmodule

// File: rtl/lpddr2_bridge.sv
// Turns level-style CPU read/write requests into single Avalon-MM transactions on
// the LPDDR2 controller local port, with a one-entry read buffer and read watchdog.
module lpddr2_bridge
    import lpddr2_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                read_req,
    input  logic                write_req,
    output logic [DATA_W-1:0]   read_data,
    output logic                busy,
    output logic                err,
    output logic [ADDR_W-1:0]   avl_addr,
    output logic [DATA_W-1:0]   avl_wdata,
    output logic [DATA_W/8-1:0] avl_be,
    output logic                avl_read,
    output logic                avl_write,
    output logic                avl_burstcount,
    input  logic [DATA_W-1:0]   avl_rdata,
    input  logic                avl_rdata_valid,
    input  logic                avl_ready,
    input  logic                local_init_done
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              avl_read_q, avl_read_d;
    logic              avl_write_q, avl_write_d;

    logic              hit_c;
    logic              fill_en, upd_en, inv_en;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;

    lpddr2_rd_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_buffer (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (address),
        .hit_c       (hit_c),
        .fill_en     (fill_en),
        .fill_addr   (addr_q),
        .fill_data   (avl_rdata),
        .upd_en      (upd_en),
        .upd_addr    (addr_q),
        .upd_data    (wdata_q),
        .inv_en      (inv_en),
        .buf_valid   (buf_valid),
        .buf_data    (buf_data)
    );

    // Next-state, command latch, watchdog and buffer control
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fill_en = 1'b0;
        upd_en  = 1'b0;
        inv_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (local_init_done) begin
                    if (write_req) begin
                        state_d = ST_WR_CMD;
                        addr_d  = address;
                        wdata_d = write_data;
                    end else if (read_req && !hit_c) begin
                        state_d = ST_RD_CMD;
                        addr_d  = address;
                    end
                end
            end
            ST_WR_CMD: begin
                if (avl_ready) begin
                    upd_en  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_CMD: begin
                if (avl_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (avl_rdata_valid) begin
                    fill_en = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    inv_en  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        avl_read_d  = (state_d == ST_RD_CMD);
        avl_write_d = (state_d == ST_WR_CMD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            avl_read_q  <= 1'b0;
            avl_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            avl_read_q  <= avl_read_d;
            avl_write_q <= avl_write_d;
        end
    end

    // Stall unless idle with nothing to fetch, or in the single DONE hand-off cycle
    assign busy = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                  ((state_q == ST_IDLE) && (write_req || (read_req && !hit_c)));

    assign read_data      = buf_valid ? buf_data : '0;
    assign err            = err_q;
    assign avl_addr       = addr_q;
    assign avl_wdata      = wdata_q;
    assign avl_read       = avl_read_q;
    assign avl_write      = avl_write_q;
    assign avl_be         = '1;
    assign avl_burstcount = 1'b1;

endmodule

// File: tb/tb_lpddr2_bridge.sv
// Bench for lpddr2_bridge: acts as CPU and as an Avalon memory with programmable
// accept wait and read latency; a transaction-level model predicts every result.
module tb_lpddr2_bridge;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic          read_req, write_req;
    logic [DW-1:0] read_data;
    logic          busy, err;
    logic [AW-1:0] avl_addr;
    logic [DW-1:0] avl_wdata;
    logic [3:0]    avl_be;
    logic          avl_read, avl_write, avl_burstcount;
    logic [DW-1:0] avl_rdata;
    logic          avl_rdata_valid, avl_ready, local_init_done;

    int checks = 0;
    int errors = 0;

    lpddr2_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .read_req(read_req), .write_req(write_req), .read_data(read_data),
        .busy(busy), .err(err), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
        .avl_be(avl_be), .avl_read(avl_read), .avl_write(avl_write),
        .avl_burstcount(avl_burstcount), .avl_rdata(avl_rdata),
        .avl_rdata_valid(avl_rdata_valid), .avl_ready(avl_ready),
        .local_init_done(local_init_done)
    );

    always #5 clk = ~clk;

    // Memory contents before any write
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return ({5'd0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- Avalon memory (environment) ----------------
    int  ready_wait = 0;
    int  rsp_lat    = 1;
    bit  drop_reads = 1'b0;
    bit  slave_en   = 1'b1;
    int  n_wr_acc = 0, n_rd_acc = 0, n_wr_cyc = 0, n_rd_cyc = 0;
    int  age = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    int            pend_cnt [$];
    logic [DW-1:0] pend_dat [$];

    function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    // ready rises ready_wait cycles into a command; read data arrives rsp_lat cycles after accept
    initial begin
        avl_ready = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin pend_cnt.delete(); pend_dat.delete(); age = 0; end
            if (slave_en) begin
                avl_rdata_valid = 1'b0;
                for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
                if (pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
                    avl_rdata_valid = 1'b1;
                    avl_rdata = pend_dat.pop_front();
                    void'(pend_cnt.pop_front());
                end
                if (avl_read || avl_write) begin avl_ready = (age >= ready_wait); age++; end
                else begin avl_ready = 1'b0; age = 0; end
                if (avl_write) n_wr_cyc++;
                if (avl_read) n_rd_cyc++;
                if (avl_write && avl_ready) begin
                    n_wr_acc++; last_wr_addr = avl_addr; last_wr_data = avl_wdata;
                    dev_mem[avl_addr] = avl_wdata;
                end
                if (avl_read && avl_ready) begin
                    n_rd_acc++;
                    if (!drop_reads) begin pend_cnt.push_back(rsp_lat); pend_dat.push_back(dev_rd(avl_addr)); end
                end
            end
        end
    end

    // ---------------- Reference model (transaction level) ----------------
    bit            m_valid = 1'b0;
    logic [AW-1:0] m_tag   = '0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // CPU side: hold the request until busy drops, report data and stall cycles
    task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int budget, output logic [DW-1:0] rd, output int lat, output bit to);
        address = a; write_data = d; write_req = wr; read_req = !wr;
        lat = 0; to = 1'b0;
        #1;
        while (busy === 1'b1 && !to) begin
            @(negedge clk);
            lat++;
            if (lat > budget) to = 1'b1;
        end
        rd = read_data;
        @(negedge clk);
        read_req = 1'b0; write_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; read_req = 1'b0; write_req = 1'b0; address = '0; write_data = '0;
        local_init_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (avl_read !== 1'b0 || avl_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0/0", avl_read, avl_write); end
        checks++; if (avl_addr !== '0 || avl_wdata !== '0) begin errors++; $display("FAIL reset_cmd got addr=%h wdata=%h exp 0", avl_addr, avl_wdata); end
        checks++; if (read_data !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", read_data); end
        checks++; if (avl_be !== 4'hF || avl_burstcount !== 1'b1) begin errors++; $display("FAIL const_be_burst got be=%h bc=%b exp F/1", avl_be, avl_burstcount); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init_hold();
        int bad_busy = 0;
        int rd_seen  = 0;
        local_init_done = 1'b0; address = 27'h0100; read_req = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (avl_read !== 1'b0) rd_seen++;
        end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL init_busy got %0d idle cycles exp 0", bad_busy); end
        checks++; if (rd_seen != 0) begin errors++; $display("FAIL init_no_read got %0d avl_read cycles exp 0", rd_seen); end
        read_req = 1'b0; local_init_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [DW-1:0] rd; int lat; bit to;
        int w0 = n_wr_acc, c0 = n_wr_cyc;
        ready_wait = 3;
        do_access(1'b1, 27'h1000, 32'hDEAD_BEEF, 50, rd, lat, to);
        ref_mem[27'h1000] = 32'hDEAD_BEEF;
        checks++; if (to || lat != 5) begin errors++; $display("FAIL wr_latency got %0d (to=%0b) exp 5", lat, to); end
        checks++; if (n_wr_cyc - c0 != 4) begin errors++; $display("FAIL wr_strobe_cycles got %0d exp 4", n_wr_cyc - c0); end
        checks++; if (last_wr_addr !== 27'h1000 || last_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_payload got %h/%h exp 1000/deadbeef", last_wr_addr, last_wr_data); end
        repeat (5) @(negedge clk);
        checks++; if (n_wr_acc - w0 != 1) begin errors++; $display("FAIL wr_single got %0d writes exp 1", n_wr_acc - w0); end
    endtask

    task automatic test_read_miss();
        logic [DW-1:0] rd; int lat; bit to;
        int r0 = n_rd_acc, c0;
        int bad = 0;
        dev_mem[27'h2000] = 32'h1234_5678; ref_mem[27'h2000] = 32'h1234_5678;
        ready_wait = 0; rsp_lat = 5;
        do_access(1'b0, 27'h2000, '0, 50, rd, lat, to);
        m_valid = 1'b1; m_tag = 27'h2000; m_data = 32'h1234_5678;
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_miss_data got %h exp 12345678", rd); end
        checks++; if (to || lat != 7) begin errors++; $display("FAIL rd_miss_latency got %0d (to=%0b) exp 7", lat, to); end
        checks++; if (n_rd_acc - r0 != 1) begin errors++; $display("FAIL rd_miss_count got %0d exp 1", n_rd_acc - r0); end
        c0 = n_rd_cyc;
        address = 27'h2000; read_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || read_data !== 32'h1234_5678) bad++;
        end
        read_req = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL rd_hold_hit got %0d bad cycles exp 0", bad); end
        checks++; if (n_rd_cyc != c0) begin errors++; $display("FAIL rd_hold_no_traffic got %0d read cycles exp 0", n_rd_cyc - c0); end
        @(negedge clk);
    endtask

    task automatic test_write_through();
        logic [DW-1:0] rd; int lat; bit to;
        int r0 = n_rd_acc;
        ready_wait = 1;
        do_access(1'b0, 27'h2000, '0, 50, rd, lat, to);
        checks++; if (to || lat != 0 || rd !== 32'h1234_5678) begin errors++; $display("FAIL wt_hit got lat=%0d data=%h exp 0/12345678", lat, rd); end
        do_access(1'b1, 27'h2000, 32'hCAFE_F00D, 50, rd, lat, to);
        ref_mem[27'h2000] = 32'hCAFE_F00D; m_data = 32'hCAFE_F00D;
        checks++; if (to || lat != 3) begin errors++; $display("FAIL wt_write_latency got %0d exp 3", lat); end
        do_access(1'b0, 27'h2000, '0, 50, rd, lat, to);
        checks++; if (to || lat != 0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL wt_reread got lat=%0d data=%h exp 0/cafef00d", lat, rd); end
        checks++; if (n_rd_acc != r0) begin errors++; $display("FAIL wt_no_read got %0d reads exp 0", n_rd_acc - r0); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd; int lat; bit to;
        int r0;
        ready_wait = 0; drop_reads = 1'b1;
        do_access(1'b0, 27'h3000, '0, TO + 100, rd, lat, to);
        m_valid = 1'b0;
        checks++; if (to || lat != int'(TO) + 2) begin errors++; $display("FAIL to_latency got %0d (to=%0b) exp %0d", lat, to, TO + 2); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL to_rdata got %h exp 0", rd); end
        drop_reads = 1'b0; rsp_lat = 2; r0 = n_rd_acc;
        do_access(1'b0, 27'h3000, '0, 50, rd, lat, to);
        m_valid = 1'b1; m_tag = 27'h3000; m_data = ref_rd(27'h3000);
        checks++; if (n_rd_acc - r0 != 1) begin errors++; $display("FAIL to_reissue got %0d reads exp 1", n_rd_acc - r0); end
        checks++; if (to || rd !== ref_rd(27'h3000) || lat != 4) begin errors++; $display("FAIL to_reread got data=%h lat=%0d exp %h/4", rd, lat, ref_rd(27'h3000)); end
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [4];
        logic [DW-1:0] rd, d, exp_rd;
        logic [AW-1:0] a;
        int lat, exp_lat, w, l, r0, w0, exp_r, exp_w;
        bit to, wr;
        pool[0] = 27'h0010; pool[1] = 27'h0011; pool[2] = 27'h2000; pool[3] = 27'h7FF_FFFF;
        for (int n = 0; n < 40; n++) begin
            a = pool[$urandom_range(0, 3)];
            wr = ($urandom_range(0, 2) == 0);
            d = $urandom;
            w = $urandom_range(0, 3); l = $urandom_range(1, 4);
            ready_wait = w; rsp_lat = l;
            exp_rd = '0; exp_r = 0; exp_w = 0;
            if (wr) begin
                exp_lat = 2 + w; exp_w = 1;
                ref_mem[a] = d;
                if (m_valid && m_tag == a) m_data = d;
            end else if (m_valid && m_tag == a) begin
                exp_lat = 0; exp_rd = m_data;
            end else begin
                exp_lat = 2 + w + l; exp_r = 1; exp_rd = ref_rd(a);
                m_valid = 1'b1; m_tag = a; m_data = exp_rd;
            end
            r0 = n_rd_acc; w0 = n_wr_acc;
            do_access(wr, a, d, 50, rd, lat, to);
            checks++; if (to || lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d (to=%0b) exp %0d", n, lat, to, exp_lat); end
            checks++; if (n_rd_acc - r0 != exp_r || n_wr_acc - w0 != exp_w) begin errors++; $display("FAIL rnd%0d_traffic got rd=%0d wr=%0d exp %0d/%0d", n, n_rd_acc - r0, n_wr_acc - w0, exp_r, exp_w); end
            if (!wr) begin
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_data @%h got %h exp %h", n, a, rd, exp_rd); end
            end else begin
                checks++; if (last_wr_addr !== a || last_wr_data !== d) begin errors++; $display("FAIL rnd%0d_wpayload got %h/%h exp %h/%h", n, last_wr_addr, last_wr_data, a, d); end
            end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] rd; int lat; bit to;
        int r0;
        slave_en = 1'b0; avl_ready = 1'b1; avl_rdata_valid = 1'b0;
        address = 27'h4000; read_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1 || avl_read !== 1'b0) begin errors++; $display("FAIL mid_in_wait got busy=%b rd=%b exp 1/0", busy, avl_read); end
        read_req = 1'b0; rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || avl_read !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset got busy=%b rd=%b err=%b exp 0/0/0", busy, avl_read, err); end
        avl_rdata = 32'hBAD0_BAD0; avl_rdata_valid = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); avl_rdata_valid = 1'b0; avl_ready = 1'b0;
        m_valid = 1'b0;
        checks++; if (read_data !== '0) begin errors++; $display("FAIL mid_no_capture got %h exp 0", read_data); end
        slave_en = 1'b1; ready_wait = 0; rsp_lat = 1; r0 = n_rd_acc;
        @(negedge clk);
        do_access(1'b0, 27'h4000, '0, 50, rd, lat, to);
        checks++; if (n_rd_acc - r0 != 1 || rd !== ref_rd(27'h4000)) begin errors++; $display("FAIL mid_refetch got reads=%0d data=%h exp 1/%h", n_rd_acc - r0, rd, ref_rd(27'h4000)); end
    endtask

    initial begin
        test_reset();
        test_init_hold();
        test_write();
        test_read_miss();
        test_write_through();
        test_timeout();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
